// File: rtl/bram_sp_param_if.sv
// Access port of the parametrised single-port RAM: clear request, lane-masked write, read and status.
// The master drives the request fields; the slave returns read data, read-valid and clear-busy.
interface bram_sp_param_if #(
    parameter int DATA_W = 4,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 5
);
    localparam int NL = DATA_W / LANE_W;

    logic              clr;
    logic              we;
    logic [NL-1:0]     be;
    logic              re;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dout;
    logic              rvalid;
    logic              busy;

    modport master (
        output clr, we, be, re, a, di,
        input  dout, rvalid, busy
    );

    modport slave (
        input  clr, we, be, re, a, di,
        output dout, rvalid, busy
    );
endinterface

// File: rtl/bram_sp_param.sv
// Single-port RAM, lane write enables, read latency 0/1 by READ_MODE (+1 with BRAM_SP_PARAM_OUT_REG_EN);
// no backpressure: one access per cycle, all accesses dropped while the clear sequencer holds busy.
module bram_sp_param #(
    parameter int                DATA_W    = 4,
    parameter int                LANE_W    = 4,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                READ_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input logic           clk,
    input logic           rst_n,
    bram_sp_param_if.slave bus
);
    localparam int                NL   = DATA_W / LANE_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy_q;
    logic [DATA_W-1:0] ram [DEPTH];

    logic              in_range;
    logic              acc;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_dat;
    logic              rd_vld;

    // One extra address bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, bus.a} < (ADDR_W + 1)'(DEPTH));
    assign acc      = bus.re & ~busy_q;
    assign old_word = in_range ? ram[bus.a] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (bus.clr) begin
                        state  <= CLEAR;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_q <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Array has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            ram[cnt] <= INIT_VAL;
        end else if (bus.we && in_range) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.be[i]) begin
                    ram[bus.a][i*LANE_W +: LANE_W] <= bus.di[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    generate
        if (READ_MODE == 0) begin : g_async
            assign rd_dat = old_word;
            assign rd_vld = acc;
        end else begin : g_sync
            logic [DATA_W-1:0] rd_word;
            logic [DATA_W-1:0] q;
            logic              v;

            if (READ_MODE == 2) begin : g_wf
                always_comb begin
                    rd_word = old_word;
                    if (bus.we && in_range) begin
                        for (int i = 0; i < NL; i++) begin
                            if (bus.be[i]) begin
                                rd_word[i*LANE_W +: LANE_W] = bus.di[i*LANE_W +: LANE_W];
                            end
                        end
                    end
                end
            end else begin : g_rf
                assign rd_word = old_word;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                    v <= 1'b0;
                end else begin
                    v <= acc;
                    if (acc) begin
                        q <= rd_word;
                    end
                end
            end

            assign rd_dat = q;
            assign rd_vld = v;
        end
    endgenerate

`ifdef BRAM_SP_PARAM_OUT_REG_EN
    logic [DATA_W-1:0] o_dat;
    logic              o_vld;

    // Not flushed by clr: a read already in flight still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dat <= '0;
            o_vld <= 1'b0;
        end else begin
            o_vld <= rd_vld;
            if (rd_vld) begin
                o_dat <= rd_dat;
            end
        end
    end

    assign bus.dout   = o_dat;
    assign bus.rvalid = o_vld;
`else
    assign bus.dout   = rd_dat;
    assign bus.rvalid = rd_vld;
`endif

    assign bus.busy = busy_q;
endmodule

// File: doc/bram_sp_param.md
Name: bram_sp_param

Overview:
- Parametrised single-port block RAM; next generation of the team's fixed 32x4 single-port RAM.
- Generalised in width and depth, with per-lane write enables and a selectable read mode (asynchronous, synchronous read-first, synchronous write-first).
- Has a hardware clear sequencer that fills the array with INIT_VAL after reset or on request.
- Used as a general storage primitive in the example designs; maps to block RAM in sync modes and distributed RAM in async mode.

Parameters:
- DATA_W, 4, word width in bits; must be a multiple of LANE_W.
- LANE_W, 4, bits per write lane; NL = DATA_W/LANE_W lanes.
- ADDR_W, 5, address width.
- DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- READ_MODE, 0, read mode: 0 = async read, 1 = sync read-first, 2 = sync write-first.
- INIT_VAL, 0, DATA_W-bit value written by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  single-cycle pulse; starts a full clear of the array.
- we  in  1  write enable.
- be  in  NL  lane enables; lane i covers di[i*LANE_W +: LANE_W].
- re  in  1  read enable.
- a  in  ADDR_W  word address.
- di  in  DATA_W  write data.
- do  out  DATA_W  read data.
- rvalid  out  1  do holds data for an accepted read.
- busy  out  1  clear sequencer active; accesses ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = CLEAR, clear counter = 0, busy = 1, rvalid = 0.
  - Registered do = 0 (modes 1/2).
  - Array contents are not reset.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes INIT_VAL to ram[cnt], then cnt increments.
  - When cnt == DEPTH-1, that write completes and the next state is READY.
  - busy deasserts on the edge that enters READY, i.e. exactly DEPTH rising edges after rst_n release or after the clr edge.
- READY:
  - clr sampled high -> CLEAR next cycle with cnt = 0.
  - An access in the same cycle as clr is still performed.
- clr during CLEAR: restarts from cnt = 0; the total clear time is DEPTH cycles from the last clr.
- While busy:
  - we and re are ignored; rvalid = 0.
  - Registered do holds its value.
  - Mode 0 do still shows ram[a]; its content is not meaningful.
- Write (READY, we = 1, a < DEPTH): lane i of ram[a] <= di lane i for every be[i] = 1. Other lanes are unchanged. be = 0 means no write.
- Out-of-range address (a >= DEPTH):
  - Write is dropped.
  - Read returns 0, with rvalid following the normal rules.
- READ_MODE 0:
  - do = ram[a] combinationally at all times.
  - rvalid = re & ~busy, combinational.
  - A write becomes visible on do after the write edge.
- READ_MODE 1:
  - On an edge with re & ~busy: do <= ram[a] before any same-cycle write (old data); rvalid <= 1.
  - Otherwise rvalid <= 0 and do holds.
  - Latency 1 cycle.
- READ_MODE 2:
  - As mode 1, but a same-cycle write to the same address returns the merged word: new data in enabled lanes, old data in the rest.
- Back-to-back reads: one read per cycle, no bubbles.

Optional Feature:
- Macro: BRAM_SP_PARAM_OUT_REG_EN.
- Defined:
  - Adds one output register stage after the read path: do and rvalid are delayed one extra cycle, aligned together.
  - Mode 0 becomes 1-cycle latency; modes 1/2 become 2-cycle latency.
  - Output register resets to do = 0, rvalid = 0.
  - The stage captures only when its input rvalid = 1, otherwise holds.
  - The stage is not flushed by clr; an in-flight read completes.
- Undefined: latencies as in Behaviour; no extra registers.

Test Plan:
- Defaults, release rst_n; hold clr = 0 -> busy = 1 for exactly 32 edges then 0; read all 32 addresses -> do = 0 each.
- Mode 1, DATA_W=16, LANE_W=8: write a=3 di=0xABCD be=2'b11, then a=3 di=0x1234 be=2'b01 -> read a=3 gives 0xAB34, rvalid exactly 1 cycle after re.
- Mode 1 vs mode 2, ram[7]=0x5; same cycle we=1 re=1 a=7 di=0xA -> mode 1 do=0x5, mode 2 do=0xA; next read gives 0xA in both.
- DEPTH=20, ADDR_W=5: write a=25 di=0xF, read a=25 -> do=0, rvalid=1; ram[0..19] unchanged.
- Write ram[4]=0x9, pulse clr, then clr again 5 cycles later -> busy high 5+DEPTH cycles total; we/re ignored, rvalid=0 meanwhile; afterwards ram[4]=INIT_VAL.
- Assert rst_n low mid-clear and mid-read (with and without BRAM_SP_PARAM_OUT_REG_EN) -> rvalid=0 and registered do=0 immediately, without waiting for a clock edge; clear restarts from address 0.
